// File: rtl/axi2mem_w_buffer.sv
// W-channel beat FIFO with a complete-burst counter; a pushed beat is visible one cycle later, no fall-through.
// Upstream is stalled while full (ready depends on registered occupancy only); downstream pops via valid/ready.
module axi2mem_w_buffer #(
  parameter int DATA_WIDTH   = 64,
  parameter int USER_WIDTH   = 6,
  parameter int BUFFER_DEPTH = 4,
  localparam int STRB_WIDTH  = DATA_WIDTH / 8,
  localparam int CW          = $clog2(BUFFER_DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  slave_valid_i,
  input  logic [DATA_WIDTH-1:0] slave_data_i,
  input  logic [STRB_WIDTH-1:0] slave_strb_i,
  input  logic [USER_WIDTH-1:0] slave_user_i,
  input  logic                  slave_last_i,
  output logic                  slave_ready_o,
  output logic                  master_valid_o,
  output logic [DATA_WIDTH-1:0] master_data_o,
  output logic [STRB_WIDTH-1:0] master_strb_o,
  output logic [USER_WIDTH-1:0] master_user_o,
  output logic                  master_last_o,
  input  logic                  master_ready_i,
  output logic [CW-1:0]         bursts_o,
  output logic                  burst_avail_o
);

  localparam int PW = $clog2(BUFFER_DEPTH);
  localparam int EW = DATA_WIDTH + STRB_WIDTH + USER_WIDTH + 1;

  logic [EW-1:0] mem [BUFFER_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] bursts;
  logic          push;
  logic          pop;
  logic          burst_in;
  logic          burst_out;

  assign slave_ready_o  = (count != CW'(BUFFER_DEPTH));
  assign master_valid_o = (count != '0);
  assign push           = slave_valid_i & slave_ready_o;
  assign pop            = master_valid_o & master_ready_i;
  assign burst_in       = push & slave_last_i;
  assign burst_out      = pop & master_last_o;

  // Head is read straight from storage; when empty it shows a stale entry.
  assign {master_data_o, master_strb_o, master_user_o, master_last_o} = mem[rd_ptr];
  assign bursts_o       = bursts;
  assign burst_avail_o  = (bursts != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BUFFER_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      bursts <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {slave_data_i, slave_strb_i, slave_user_i, slave_last_i};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase

      // A burst only counts once its last beat is stored.
      case ({burst_in, burst_out})
        2'b10:   bursts <= bursts + CW'(1);
        2'b01:   bursts <= bursts - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi2mem_w_buffer.sv
module tb_axi2mem_w_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        slave_valid_i;
  logic [63:0] slave_data_i;
  logic [7:0]  slave_strb_i;
  logic [5:0]  slave_user_i;
  logic        slave_last_i;
  logic        slave_ready_o;
  logic        master_valid_o;
  logic [63:0] master_data_o;
  logic [7:0]  master_strb_o;
  logic [5:0]  master_user_o;
  logic        master_last_o;
  logic        master_ready_i;
  logic [CW-1:0] bursts_o;
  logic        burst_avail_o;

  axi2mem_w_buffer #(.DATA_WIDTH(64), .USER_WIDTH(6), .BUFFER_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .slave_valid_i(slave_valid_i), .slave_data_i(slave_data_i), .slave_strb_i(slave_strb_i),
    .slave_user_i(slave_user_i), .slave_last_i(slave_last_i), .slave_ready_o(slave_ready_o),
    .master_valid_o(master_valid_o), .master_data_o(master_data_o), .master_strb_o(master_strb_o),
    .master_user_o(master_user_o), .master_last_o(master_last_o), .master_ready_i(master_ready_i),
    .bursts_o(bursts_o), .burst_avail_o(burst_avail_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  s;
    logic [5:0]  u;
    logic        l;
  } beat_t;

  beat_t       mdl[$];
  logic [63:0] out_log[$];
  int          checks = 0;
  int          failures = 0;
  bit          push_s = 1'b0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_bursts();
    int n = 0;
    foreach (mdl[i]) if (mdl[i].l) n++;
    return n;
  endfunction

  // Monitor: compares DUT against the queue model, then applies this edge's pop/push.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      mdl.delete();
      push_s = 1'b0;
    end else begin
      bit exp_ready, exp_valid, pop_m;
      int nb;
      exp_ready = (mdl.size() != DEPTH);
      exp_valid = (mdl.size() != 0);
      nb        = model_bursts();
      chk(slave_ready_o == exp_ready, "slave_ready", 64'(slave_ready_o), 64'(exp_ready));
      chk(master_valid_o == exp_valid, "master_valid", 64'(master_valid_o), 64'(exp_valid));
      chk(bursts_o == CW'(nb), "bursts", 64'(bursts_o), 64'(nb));
      chk(burst_avail_o == (nb != 0), "burst_avail", 64'(burst_avail_o), 64'(nb != 0));
      if (exp_valid) begin
        chk(master_data_o == mdl[0].d, "head_data", master_data_o, mdl[0].d);
        chk({master_strb_o, master_user_o, master_last_o} == {mdl[0].s, mdl[0].u, mdl[0].l},
            "head_side", 64'({master_strb_o, master_user_o, master_last_o}),
            64'({mdl[0].s, mdl[0].u, mdl[0].l}));
      end
      pop_m  = exp_valid && master_ready_i;
      push_s = exp_ready && slave_valid_i;
      if (pop_m) begin
        out_log.push_back(mdl[0].d);
        void'(mdl.pop_front());
      end
      if (push_s) mdl.push_back('{slave_data_i, slave_strb_i, slave_user_i, slave_last_i});
    end
  end

  // All main-thread steps start at posedge+1.
  task automatic wait_push();
    int n = 0;
    do begin
      @(posedge clk_i); #1;
      n++;
    end while (!push_s && n < 50);
    if (!push_s) chk(1'b0, "accept_timeout", 64'(n), 64'd50);
    slave_valid_i = 1'b0;
  endtask

  task automatic send(input logic [63:0] d, input logic [7:0] s, input logic [5:0] u, input logic l);
    slave_valid_i = 1'b1;
    slave_data_i  = d;
    slave_strb_i  = s;
    slave_user_i  = u;
    slave_last_i  = l;
    wait_push();
  endtask

  task automatic drain();
    int n = 0;
    master_ready_i = 1'b1;
    while (mdl.size() != 0 && n < 50) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (mdl.size() != 0) chk(1'b0, "drain_timeout", 64'(mdl.size()), 64'd0);
    master_ready_i = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk(slave_ready_o == 1'b1, {tag, "_ready"}, 64'(slave_ready_o), 64'd1);
    chk(master_valid_o == 1'b0, {tag, "_valid"}, 64'(master_valid_o), 64'd0);
    chk(bursts_o == '0 && burst_avail_o == 1'b0, {tag, "_bursts"}, 64'(bursts_o), 64'd0);
    chk(master_data_o == 64'd0, {tag, "_data"}, master_data_o, 64'd0);
  endtask

  task automatic random_traffic(input int cycles, input int ready_pct);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk_i); #1;
      if (!slave_valid_i || push_s) begin
        slave_valid_i = ($urandom_range(0, 99) < 60);
        slave_data_i  = {$urandom, $urandom};
        slave_strb_i  = 8'($urandom);
        slave_user_i  = 6'($urandom);
        slave_last_i  = ($urandom_range(0, 2) == 0);
      end
      master_ready_i = ($urandom_range(0, 99) < ready_pct);
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    slave_valid_i = 1'b0; slave_data_i = '0; slave_strb_i = '0;
    slave_user_i = '0; slave_last_i = 1'b0; master_ready_i = 1'b0;
    #1;
    check_reset_values("init_reset");
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Single beat: visible the next cycle with one burst counted.
    send(64'hDEAD_BEEF_0123_4567, 8'hFF, 6'h2A, 1'b1);
    @(negedge clk_i);
    chk(master_valid_o == 1'b1, "single_valid", 64'(master_valid_o), 64'd1);
    chk(master_data_o == 64'hDEAD_BEEF_0123_4567, "single_data", master_data_o, 64'hDEAD_BEEF_0123_4567);
    chk(bursts_o == CW'(1) && burst_avail_o, "single_bursts", 64'(bursts_o), 64'd1);
    @(posedge clk_i); #1;

    // Fill to 4, a 5th beat is held; one pop reopens ready a cycle later.
    send(64'h11, 8'h01, 6'h01, 1'b0);
    send(64'h22, 8'h03, 6'h02, 1'b0);
    send(64'h33, 8'h07, 6'h03, 1'b1);
    chk(slave_ready_o == 1'b0, "full_ready", 64'(slave_ready_o), 64'd0);
    slave_valid_i = 1'b1; slave_data_i = 64'h55; slave_strb_i = 8'h0F;
    slave_user_i = 6'h05; slave_last_i = 1'b1;
    master_ready_i = 1'b1;
    @(posedge clk_i); #1;
    master_ready_i = 1'b0;
    chk(push_s == 1'b0, "full_pop_no_accept", 64'(push_s), 64'd0);
    @(negedge clk_i);
    chk(slave_ready_o == 1'b1, "ready_after_pop", 64'(slave_ready_o), 64'd1);
    wait_push();
    drain();

    // Partial burst: no burst available until the last beat lands.
    send(64'hA0, 8'hFF, 6'h0, 1'b0);
    send(64'hA1, 8'hFF, 6'h0, 1'b0);
    send(64'hA2, 8'hFF, 6'h0, 1'b0);
    chk(burst_avail_o == 1'b0, "partial_avail", 64'(burst_avail_o), 64'd0);
    send(64'hA3, 8'hFF, 6'h0, 1'b1);
    @(negedge clk_i);
    chk(burst_avail_o == 1'b1, "partial_done_avail", 64'(burst_avail_o), 64'd1);
    @(posedge clk_i); #1;
    drain();

    // Simultaneous push and pop at occupancy 2: counts stay put.
    send(64'hB0, 8'hFF, 6'h0, 1'b1);
    send(64'hB1, 8'hFF, 6'h0, 1'b1);
    slave_valid_i = 1'b1; slave_data_i = 64'hB2; slave_last_i = 1'b1;
    master_ready_i = 1'b1;
    @(posedge clk_i); #1;
    slave_valid_i = 1'b0; master_ready_i = 1'b0;
    @(negedge clk_i);
    chk(bursts_o == CW'(2), "simul_bursts", 64'(bursts_o), 64'd2);
    chk(master_data_o == 64'hB1, "simul_head", master_data_o, 64'hB1);
    @(posedge clk_i); #1;
    drain();

    // Wrap: ten beats with toggling ready must come out 0..9 in order.
    out_log.delete();
    fork
      for (int i = 0; i < 10; i++) send(64'(i), 8'hFF, 6'(i), (i % 4) == 3);
      repeat (30) begin
        master_ready_i = ~master_ready_i;
        @(posedge clk_i); #1;
      end
    join
    drain();
    chk(out_log.size() == 10, "wrap_count", 64'(out_log.size()), 64'd10);
    for (int i = 0; i < out_log.size() && i < 10; i++)
      chk(out_log[i] == 64'(i), "wrap_order", out_log[i], 64'(i));

    // Random traffic, then an asynchronous reset in the middle of it.
    random_traffic(300, 50);
    random_traffic(200, 15);
    slave_valid_i = 1'b1;
    #2 rst_ni = 1'b0;
    #1;
    check_reset_values("mid_reset");
    slave_valid_i = 1'b0; master_ready_i = 1'b0;
    @(posedge clk_i);
    #3 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    random_traffic(300, 70);
    slave_valid_i = 1'b0;
    drain();
    @(posedge clk_i); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
